wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-port arbiter and scoreboard for the ID-stage register file. Shares the single register-file write port between the in-order pipeline writeback (requester A, no backpressure) and the multi-cycle mul/div unit (requester B, valid/ready). Tracks destination registers with outstanding multi-cycle results so ID can stall on RAW/WAW hazards. Prevents B starvation by forcing a one-cycle pipeline stall.

## Interface
- `XLEN`, 32, data width
- `MAX_WAIT`, 4, cycles B may wait ungranted before a forced stall (1..15)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `a_valid`  in  1  pipeline writeback request
- `a_rd`  in  5  pipeline destination
- `a_data`  in  XLEN  pipeline result
- `b_valid`  in  1  mul/div result request
- `b_rd`  in  5  mul/div destination
- `b_data`  in  XLEN  mul/div result
- `b_ready`  out  1  B grant, combinational
- `issue_valid`  in  1  ID issuing a multi-cycle op
- `issue_rd`  in  5  its destination
- `issue_ready`  out  1  issue accepted (no WAW), combinational
- `rs1_addr`, `rs2_addr`  in  5  ID source operands
- `rs1_busy`, `rs2_busy`  out  1  operand pending in scoreboard, combinational
- `stall_pipe`  out  1  freeze pipeline, registered
- `reg_we`  out  1  to register file write enable, registered
- `reg_waddr`  out  5  to register file write address, registered
- `reg_wdata`  out  XLEN  to register file write data, registered

## Operation
- Scoreboard `sb[31:0]`, bit 0 hard-wired 0. Issue handshake (`issue_valid && issue_ready`, `issue_rd != 0`) sets `sb[issue_rd]`; B handshake (`b_valid && b_ready`) clears `sb[b_rd]`. Same rd set and cleared in one cycle: set wins.
- `issue_ready = (issue_rd == 0) || !sb[issue_rd]`; conservative, a same-cycle B commit to that rd does not make it ready.
- `rsN_busy = (rsN_addr != 0) && sb[rsN_addr]`.
- Grant: `b_ready = b_valid && (!a_valid || state == FORCE)`. A otherwise always wins.
- Write port: the granted request (A, or B when `b_ready`) registers into `reg_we/reg_waddr/reg_wdata` next cycle. rd == 0 is consumed but produces `reg_we = 0`. No grant -> `reg_we = 0`, addr/data hold.
- In FORCE, A is not consumed; the frozen pipeline re-presents it the next cycle.
- FSM:
  - IDLE: `b_valid && !b_ready` -> WAIT, `wait_cnt = 1`.
  - WAIT: B granted -> IDLE; else `wait_cnt++`; on reaching `MAX_WAIT` -> FORCE.
  - FORCE: `stall_pipe = 1`, B granted unconditionally -> IDLE, `wait_cnt = 0`.
  - `b_valid` dropping in WAIT (protocol violation) -> IDLE.

## Timing
- Reset: `sb = 0`, state IDLE, `wait_cnt = 0`, `stall_pipe = 0`, `reg_we = 0`, `reg_waddr = 0`, `reg_wdata = 0`.
- Request to register-file write: 1 cycle. Register-file write-forwarding covers same-cycle reads.
- Worst-case B latency with continuous A traffic: `MAX_WAIT + 1` cycles from `b_valid` to `b_ready`.
- `stall_pipe` is high exactly one cycle per FORCE entry, coincident with `b_ready`.
- Scoreboard bit visible on `rsN_busy` the cycle after issue; cleared the cycle after the B grant, matching `reg_we`.
- `rst_n` low mid-WAIT/FORCE: immediate return to reset values; pending B data is dropped, and the mul/div unit is reset on the same `rst_n`.

## Structure
- Shared package `cpu_pkg`: `XLEN`, `REG_ADDR_W = 5`, FSM state enum `{IDLE, WAIT, FORCE}`.
- One sub-module, `wb_scoreboard`: the 32-bit busy vector with set/clear ports and two read ports. Arbiter FSM and write-port register stay in the top.

## Test plan
- A only: `a_valid=1, a_rd=5, a_data=0xDEADBEEF` -> next cycle `reg_we=1, reg_waddr=5, reg_wdata=0xDEADBEEF`. `b_ready=0` throughout.
- B idle-port: issue rd=7, then `b_valid` with `b_data=0x12`, `a_valid=0` -> `b_ready=1` same cycle. Write to x7 next cycle; `rs1_busy` for rs1=7 high from the cycle after issue until the cycle after the grant.
- Starvation, `MAX_WAIT=4`: `a_valid` held high, `b_valid` raised -> `stall_pipe=1` and `b_ready=1` on the 5th cycle. That cycle's A data is written only after being re-presented.
- WAW: rd=9 busy, `issue_rd=9` -> `issue_ready=0`. After the B commit to x9 -> `issue_ready=1`. Same-cycle issue and commit to x10 leaves `sb[10]=1`.
- x0: A or B writes with rd=0 -> `reg_we=0`. `issue_rd=0` -> `issue_ready=1`, `rs1_busy(0)=0`.
- Reset in FORCE: assert `rst_n=0` -> `stall_pipe`, `reg_we` and all `sb` bits go to 0 immediately, and state returns to IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and write-port arbiter state encoding
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} arb_state_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: busy vector of destinations with outstanding multi-cycle results
module wb_scoreboard import cpu_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [31:0]           busy_o,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o
);
  logic [31:0] sb_q, sb_d;
  // set is applied after clear so a same-cycle set wins; x0 never becomes busy
  always_comb sb_d = ((sb_q & ~(32'(clr_en_i) << clr_addr_i)) | (32'(set_en_i) << set_addr_i)) & ~32'h1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sb_q <= '0;
    else sb_q <= sb_d;
  assign busy_o = sb_q;
  assign rs1_busy_o = sb_q[rs1_addr_i];
  assign rs2_busy_o = sb_q[rs2_addr_i];
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback
// and the mul/div unit, with a forced one-cycle stall so mul/div cannot starve
module wb_port_arbiter import cpu_pkg::*; #(
  parameter int XLEN     = cpu_pkg::XLEN,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall_pipe,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_waddr,
  output logic [XLEN-1:0]       reg_wdata
);
  arb_state_e            state_q;
  logic [3:0]            wait_cnt_q;
  logic                  stall_q, we_q, we_d, a_take;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [31:0]           busy;

  wb_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (issue_valid && issue_ready && issue_rd != '0),
    .set_addr_i (issue_rd),
    .clr_en_i   (b_ready),
    .clr_addr_i (b_rd),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .busy_o     (busy),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  assign issue_ready = (issue_rd == '0) || !busy[issue_rd];
  assign b_ready = b_valid && (!a_valid || state_q == FORCE);
  // in FORCE the frozen pipeline re-presents A next cycle, so it is not consumed now
  assign a_take = a_valid && state_q != FORCE;

  always_comb begin
    we_d    = b_ready ? (b_rd != '0) : a_take ? (a_rd != '0) : 1'b0;
    waddr_d = b_ready ? b_rd : a_take ? a_rd : waddr_q;
    wdata_d = b_ready ? b_data : a_take ? a_data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (b_valid && !b_ready) begin
            state_q    <= (MAX_WAIT == 1) ? FORCE : WAIT;
            stall_q    <= (MAX_WAIT == 1);
            wait_cnt_q <= 4'd1;
          end
        WAIT:
          if (!b_valid || b_ready) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
            if (wait_cnt_q + 4'd1 == 4'(MAX_WAIT)) begin
              state_q <= FORCE;
              stall_q <= 1'b1;
            end
          end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
          stall_q    <= 1'b0;
        end
      endcase
    end

  assign stall_pipe = stall_q;
  assign reg_we     = we_q;
  assign reg_waddr  = waddr_q;
  assign reg_wdata  = wdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of arbitration, scoreboard, x0 and reset behaviour
module tb_wb_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_valid = 0, b_valid = 0, issue_valid = 0;
  logic [4:0]  a_rd = 0, b_rd = 0, issue_rd = 0, rs1_addr = 0, rs2_addr = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic        b_ready, issue_ready, rs1_busy, rs2_busy, stall_pipe, reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  int n_chk = 0, n_fail = 0;
  wb_port_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .stall_pipe(stall_pipe), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(string t, logic [31:0] o, logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    tick;
    chk("rst_we", reg_we, 1'b0);
    chk("rst_waddr", reg_waddr, 5'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_stall", stall_pipe, 1'b0);
    chk("rst_busy", rs1_busy, 1'b0);
    rst_n = 1'b1;
    tick;
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1 chk("a_bready", b_ready, 1'b0);
    tick;
    chk("a_we", reg_we, 1'b1);
    chk("a_waddr", reg_waddr, 5'd5);
    chk("a_wdata", reg_wdata, 32'hDEADBEEF);
    a_valid = 0;
    tick;
    chk("idle_we", reg_we, 1'b0);
    chk("idle_hold_addr", reg_waddr, 5'd5);
    chk("idle_hold_data", reg_wdata, 32'hDEADBEEF);
    issue_valid = 1; issue_rd = 7;
    #1 chk("iss7_ready", issue_ready, 1'b1);
    chk("iss7_busy_pre", rs1_busy, 1'b0);
    tick;
    issue_valid = 0;
    chk("iss7_busy", rs1_busy, 1'b1);
    chk("iss7_busy2", rs2_busy, 1'b1);
    b_valid = 1; b_rd = 7; b_data = 32'h12;
    #1 chk("b7_ready", b_ready, 1'b1);
    chk("b7_busy_grant", rs1_busy, 1'b1);
    tick;
    b_valid = 0;
    chk("b7_we", reg_we, 1'b1);
    chk("b7_waddr", reg_waddr, 5'd7);
    chk("b7_wdata", reg_wdata, 32'h12);
    chk("b7_busy_clr", rs1_busy, 1'b0);
    a_valid = 1; a_rd = 3; b_valid = 1; b_rd = 4; b_data = 32'hB4;
    for (int c = 1; c <= 4; c++) begin
      a_data = 32'(c);
      #1 chk("starve_bready", b_ready, 1'b0);
      chk("starve_stall", stall_pipe, 1'b0);
      tick;
      chk("starve_a_wdata", reg_wdata, 32'(c));
    end
    a_data = 32'h5;
    #1 chk("force_bready", b_ready, 1'b1);
    chk("force_stall", stall_pipe, 1'b1);
    tick;
    chk("force_waddr", reg_waddr, 5'd4);
    chk("force_wdata", reg_wdata, 32'hB4);
    chk("force_stall_drop", stall_pipe, 1'b0);
    b_valid = 0;
    #1 chk("after_bready", b_ready, 1'b0);
    tick;
    chk("repres_waddr", reg_waddr, 5'd3);
    chk("repres_wdata", reg_wdata, 32'h5);
    a_valid = 0;
    issue_valid = 1; issue_rd = 9; rs1_addr = 9;
    tick;
    #1 chk("waw9_block", issue_ready, 1'b0);
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    #1 chk("waw9_conservative", issue_ready, 1'b0);
    chk("waw9_bready", b_ready, 1'b1);
    tick;
    b_valid = 0;
    #1 chk("waw9_free", issue_ready, 1'b1);
    chk("waw9_busy", rs1_busy, 1'b0);
    issue_rd = 10; b_valid = 1; b_rd = 10; rs1_addr = 10; rs2_addr = 10;
    tick;
    issue_valid = 0; b_valid = 0;
    chk("x10_set_wins", rs1_busy, 1'b1);
    chk("x10_set_wins2", rs2_busy, 1'b1);
    a_valid = 1; a_rd = 0; a_data = 32'hAA;
    tick;
    chk("x0_a_we", reg_we, 1'b0);
    a_valid = 0; b_valid = 1; b_rd = 0; b_data = 32'hBB;
    #1 chk("x0_b_ready", b_ready, 1'b1);
    tick;
    b_valid = 0;
    chk("x0_b_we", reg_we, 1'b0);
    issue_valid = 1; issue_rd = 0;
    #1 chk("x0_issue_ready", issue_ready, 1'b1);
    tick;
    issue_valid = 0; rs1_addr = 0;
    #1 chk("x0_busy", rs1_busy, 1'b0);
    rs2_addr = 12; issue_valid = 1; issue_rd = 12;
    tick;
    issue_valid = 0;
    chk("x12_busy", rs2_busy, 1'b1);
    a_valid = 1; a_rd = 6; a_data = 32'h66; b_valid = 1; b_rd = 12;
    repeat (4) tick;
    chk("rf_stall", stall_pipe, 1'b1);
    chk("rf_we", reg_we, 1'b1);
    rst_n = 1'b0;
    #1 chk("rf_rst_stall", stall_pipe, 1'b0);
    chk("rf_rst_we", reg_we, 1'b0);
    chk("rf_rst_sb12", rs2_busy, 1'b0);
    chk("rf_rst_sb10", rs1_busy | dut.u_sb.busy_o[10], 1'b0);
    chk("rf_rst_idle", b_ready, 1'b0);
    #1 rst_n = 1'b1;
    a_valid = 0;
    #1 chk("post_rst_bready", b_ready, 1'b1);
    tick;
    b_valid = 0;
    chk("post_rst_waddr", reg_waddr, 5'd12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
